bus_rd_responder: RTL and testbench
===================================

Name: bus_rd_responder

Overview:
- Responder end of the CPU IO synchronization interface (req/ack/adr/dtr) used by the instruction prefetcher.
- Accepts a 20-bit word-address read request and runs a read cycle on the external 16-bit memory bus with programmable wait states.
- Returns the word with a one-cycle ack pulse.
- Holds a one-word next-address speculation buffer, so sequential fetches hit with 1-cycle latency.

Parameters:
- WS, 2, minimum wait states per external read (cycles of mem_oe_n low = WS+1 minimum, plus mem_rdy stretch).
- SPEC, 1, 1 enables next-word speculation; 0 disables it (every request is a miss).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- req  input  1  read request from initiator; level, registered by initiator.
- adr  input  20  word address; valid while req=1.
- ack  output  1  one-cycle pulse; dtr valid in the same cycle.
- dtr  output  16  read data; holds last acked value between acks.
- inv  input  1  invalidate speculation buffer (memory written by another master).
- mem_adr  output  20  external word address.
- mem_oe_n  output  1  external output enable, active low.
- mem_din  input  16  external read data.
- mem_rdy  input  1  external ready, sampled on posedge.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, ack=0, dtr=0, mem_oe_n=1, mem_adr=0, sbuf_vld=0, pend=0. Reset aborts any external cycle immediately.
- States: IDLE, DRD (demand read), SRD (speculative read), DISC (finish discarded spec read).
- IDLE, req=1:
  - If sbuf_vld && sbuf_adr==adr: hit. dtr<=sbuf_dat, ack=1 the next cycle, sbuf_vld<=0. Then go to SRD at adr+1 if SPEC, else IDLE.
  - Otherwise: miss. Latch adr to mem_adr, mem_oe_n<=0, cnt<=WS, go to DRD.
- DRD: cnt decrements to 0. At the first posedge with cnt==0 && mem_rdy:
  - dtr<=mem_din, ack<=1 for one cycle, mem_oe_n<=1.
  - Next state is SRD at mem_adr+1 (SPEC=1) or IDLE.
- SRD: same timing as DRD. On completion, sbuf_dat<=mem_din, sbuf_adr<=address, sbuf_vld<=1 unless killed; then go to IDLE.
- req seen during SRD:
  - adr equals the spec address: set pend. On completion, deliver directly: dtr, ack, sbuf_vld stays 0, chain the next SRD.
  - adr differs: set kill. The spec cycle completes without being aborted. Then start DRD at the latched new adr.
- inv during SRD sets kill. inv in any state clears sbuf_vld the same edge. inv and hit in the same cycle: inv wins, so the request is treated as a miss.
- Address arithmetic is modulo 2^20: speculation after 0xFFFFF targets 0x00000.
- req is not sampled in the cycle ack is high. The initiator updates adr on that edge; the next cycle samples the new adr.
- req deasserting while DRD is busy: the cycle completes and ack still pulses exactly once. The initiator discards it.
- Exactly one ack per accepted request. ack is never asserted with mem_oe_n transitioning to a new cycle in the same cycle.
- Latency from accept edge to ack high:
  - Miss: WS+1 cycles plus mem_rdy stall.
  - Hit: 1 cycle.
  - Pending spec: remaining spec cycles.

Test Plan:
- WS=2, mem_rdy=1, SPEC=0, req adr=0x00010 -> mem_oe_n low 3 cycles, ack 1 cycle with dtr=mem[0x10], mem_adr=0x00010.
- SPEC=1, reqs at 0x100 then 0x101 after the spec read completes -> second ack 1 cycle after accept, no new oe cycle for 0x101, spec read of 0x102 starts.
- SPEC=1, request 0x101 arrives mid-SRD -> single ack when the spec read finishes; request 0x300 mid-SRD -> spec cycle finishes, then DRD at 0x300, exactly one ack with mem[0x300].
- mem_rdy held low 4 extra cycles -> ack delayed 4 cycles, dtr stable at the previous value until then.
- inv pulsed while sbuf_vld=1, then req at sbuf_adr -> miss path (WS+1 latency), data from mem (updated value).
- rst_n=0 mid-DRD -> next cycle mem_oe_n=1, ack=0, dtr=0; adr 0xFFFFF hit chains spec to 0x00000.

Source files
------------

// File: rtl/bus_rd_responder_if.sv
// Read-request / external-memory signal bundle for the prefetch read responder.
// The slave view belongs to the responder; the master view is the initiator plus memory side.
interface bus_rd_responder_if;
    logic        req;
    logic [19:0] adr;
    logic        ack;
    logic [15:0] dtr;
    logic        inv;
    logic [19:0] mem_adr;
    logic        mem_oe_n;
    logic [15:0] mem_din;
    logic        mem_rdy;

    modport slave (
        input  req, adr, inv, mem_din, mem_rdy,
        output ack, dtr, mem_adr, mem_oe_n
    );

    modport master (
        output req, adr, inv, mem_din, mem_rdy,
        input  ack, dtr, mem_adr, mem_oe_n
    );
endinterface

// File: rtl/bus_rd_responder.sv
// Prefetch read responder: serves word reads from an external 16-bit memory with
// programmable wait states, keeping a one-word next-address speculation buffer.
// Every external cycle keeps mem_oe_n high for at least the ack cycle before a new
// cycle starts, so ack never coincides with the start of a fresh memory cycle.
module bus_rd_responder #(
    parameter int WS   = 2,
    parameter int SPEC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_rd_responder_if.slave bus
);
    localparam int CW = (WS < 1) ? 1 : $clog2(WS + 1);
    localparam logic [CW-1:0] WS_CNT = CW'(WS);

    typedef enum logic [1:0] {IDLE, DRD, SRD, DISC} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ack, ack_nxt;
    logic [15:0]   dtr, dtr_nxt;
    logic          mem_oe_n, oe_nxt;
    logic [19:0]   mem_adr, adr_nxt;
    logic          sbuf_vld, sbuf_vld_nxt;
    logic [19:0]   sbuf_adr, sbuf_adr_nxt;
    logic [15:0]   sbuf_dat, sbuf_dat_nxt;
    logic          pend, pend_nxt;
    logic          dmd, dmd_nxt;
    logic [19:0]   nadr, nadr_nxt;

    logic active, done, take;

    // A request is never sampled while its predecessor's ack is on the bus.
    assign take   = bus.req && !ack;
    assign active = !mem_oe_n;
    assign done   = active && (cnt == '0) && bus.mem_rdy;

    assign bus.ack      = ack;
    assign bus.dtr      = dtr;
    assign bus.mem_adr  = mem_adr;
    assign bus.mem_oe_n = mem_oe_n;

    // Next-state and next-register values for the read sequencer.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ack_nxt      = 1'b0;
        dtr_nxt      = dtr;
        oe_nxt       = mem_oe_n;
        adr_nxt      = mem_adr;
        sbuf_vld_nxt = sbuf_vld;
        sbuf_adr_nxt = sbuf_adr;
        sbuf_dat_nxt = sbuf_dat;
        pend_nxt     = pend;
        dmd_nxt      = dmd;
        nadr_nxt     = nadr;

        if (active && cnt != '0)
            cnt_nxt = cnt - 1'b1;

        case (state)
            IDLE: begin
                if (take) begin
                    if (sbuf_vld && !bus.inv && sbuf_adr == bus.adr) begin
                        ack_nxt      = 1'b1;
                        dtr_nxt      = sbuf_dat;
                        sbuf_vld_nxt = 1'b0;
                        if (SPEC != 0) begin
                            adr_nxt   = bus.adr + 20'd1;
                            state_nxt = SRD;
                        end
                    end else begin
                        adr_nxt   = bus.adr;
                        oe_nxt    = 1'b0;
                        cnt_nxt   = WS_CNT;
                        state_nxt = DRD;
                    end
                end
            end
            DRD: begin
                if (!active) begin
                    oe_nxt  = 1'b0;
                    cnt_nxt = WS_CNT;
                end else if (done) begin
                    ack_nxt = 1'b1;
                    dtr_nxt = bus.mem_din;
                    oe_nxt  = 1'b1;
                    if (SPEC != 0) begin
                        adr_nxt   = mem_adr + 20'd1;
                        state_nxt = SRD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            SRD, DISC: begin
                // Capture a request arriving during the speculative cycle.
                // An invalidate turns a pending hit into a fresh demand read.
                if (state == SRD && bus.inv) begin
                    state_nxt = DISC;
                    if (pend) begin
                        pend_nxt = 1'b0;
                        dmd_nxt  = 1'b1;
                        nadr_nxt = mem_adr;
                    end else if (take) begin
                        dmd_nxt  = 1'b1;
                        nadr_nxt = bus.adr;
                    end
                end else if (state == SRD && !pend && take) begin
                    if (bus.adr == mem_adr) begin
                        pend_nxt = 1'b1;
                    end else begin
                        dmd_nxt   = 1'b1;
                        nadr_nxt  = bus.adr;
                        state_nxt = DISC;
                    end
                end else if (state == DISC && !dmd && take) begin
                    dmd_nxt  = 1'b1;
                    nadr_nxt = bus.adr;
                end

                if (!active) begin
                    oe_nxt  = 1'b0;
                    cnt_nxt = WS_CNT;
                end else if (done) begin
                    oe_nxt = 1'b1;
                    if (state_nxt == DISC) begin
                        if (dmd_nxt) begin
                            adr_nxt   = nadr_nxt;
                            state_nxt = DRD;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (pend_nxt) begin
                        ack_nxt   = 1'b1;
                        dtr_nxt   = bus.mem_din;
                        adr_nxt   = mem_adr + 20'd1;
                        state_nxt = SRD;
                    end else begin
                        sbuf_dat_nxt = bus.mem_din;
                        sbuf_adr_nxt = mem_adr;
                        sbuf_vld_nxt = 1'b1;
                        state_nxt    = IDLE;
                    end
                    pend_nxt = 1'b0;
                    dmd_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (bus.inv)
            sbuf_vld_nxt = 1'b0;
    end

    // Control and bus-visible registers; reset also aborts any external cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ack      <= 1'b0;
            dtr      <= '0;
            mem_oe_n <= 1'b1;
            mem_adr  <= '0;
            sbuf_vld <= 1'b0;
            pend     <= 1'b0;
            dmd      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ack      <= ack_nxt;
            dtr      <= dtr_nxt;
            mem_oe_n <= oe_nxt;
            mem_adr  <= adr_nxt;
            sbuf_vld <= sbuf_vld_nxt;
            pend     <= pend_nxt;
            dmd      <= dmd_nxt;
        end
    end

    // Buffer contents and the deferred demand address are qualified by valid flags.
    always_ff @(posedge clk) begin
        sbuf_adr <= sbuf_adr_nxt;
        sbuf_dat <= sbuf_dat_nxt;
        nadr     <= nadr_nxt;
    end
endmodule

// File: tb/tb_bus_rd_responder.sv
// Bench for bus_rd_responder: a cycle table on a non-speculating instance and
// hand-written sequences on a speculating instance. Memory word = adr ^ A5C3 ^ bump.
module tb_bus_rd_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rdy;
    logic [15:0] bump;
    int          errors = 0;
    int          checks = 0;
    int          n;

    bus_rd_responder_if bi0();
    bus_rd_responder_if bi1();

    assign bi0.mem_din = bi0.mem_adr[15:0] ^ 16'hA5C3 ^ bump;
    assign bi1.mem_din = bi1.mem_adr[15:0] ^ 16'hA5C3 ^ bump;
    assign bi0.mem_rdy = rdy;
    assign bi1.mem_rdy = rdy;

    bus_rd_responder #(.WS(2), .SPEC(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bi0.slave));
    bus_rd_responder #(.WS(2), .SPEC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bi1.slave));

    typedef struct packed {
        logic        req;
        logic [19:0] adr;
        logic        rdy;
        logic        ack;
        logic        oe_n;
        logic [15:0] dtr;
        logic [19:0] madr;
    } vec_t;

    vec_t tbl [20];

    function automatic logic [15:0] memval(input logic [19:0] a);
        return a[15:0] ^ 16'hA5C3 ^ bump;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps until dut1 shows ack; n counts edges including the accepting one, -1 on timeout.
    task automatic run_to_ack(input int maxc, output int cnt_out);
        cnt_out = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (bi1.ack === 1'b1) begin
                cnt_out = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // req, adr, rdy, ack, oe_n, dtr, mem_adr
        tbl[0]  = '{1'b1, 20'h00010, 1'b1, 1'b0, 1'b0, 16'h0000, 20'h00010};
        tbl[1]  = '{1'b1, 20'h00010, 1'b1, 1'b0, 1'b0, 16'h0000, 20'h00010};
        tbl[2]  = '{1'b1, 20'h00010, 1'b1, 1'b0, 1'b0, 16'h0000, 20'h00010};
        tbl[3]  = '{1'b1, 20'h00010, 1'b1, 1'b1, 1'b1, 16'hA5D3, 20'h00010};
        tbl[4]  = '{1'b1, 20'h00020, 1'b1, 1'b0, 1'b1, 16'hA5D3, 20'h00010};
        tbl[5]  = '{1'b1, 20'h00020, 1'b0, 1'b0, 1'b0, 16'hA5D3, 20'h00020};
        tbl[6]  = '{1'b1, 20'h00020, 1'b0, 1'b0, 1'b0, 16'hA5D3, 20'h00020};
        tbl[7]  = '{1'b1, 20'h00020, 1'b0, 1'b0, 1'b0, 16'hA5D3, 20'h00020};
        tbl[8]  = '{1'b1, 20'h00020, 1'b0, 1'b0, 1'b0, 16'hA5D3, 20'h00020};
        tbl[9]  = '{1'b1, 20'h00020, 1'b0, 1'b0, 1'b0, 16'hA5D3, 20'h00020};
        tbl[10] = '{1'b1, 20'h00020, 1'b0, 1'b0, 1'b0, 16'hA5D3, 20'h00020};
        tbl[11] = '{1'b1, 20'h00020, 1'b0, 1'b0, 1'b0, 16'hA5D3, 20'h00020};
        tbl[12] = '{1'b1, 20'h00020, 1'b1, 1'b1, 1'b1, 16'hA5E3, 20'h00020};
        tbl[13] = '{1'b0, 20'h00020, 1'b1, 1'b0, 1'b1, 16'hA5E3, 20'h00020};
        tbl[14] = '{1'b1, 20'h00030, 1'b1, 1'b0, 1'b0, 16'hA5E3, 20'h00030};
        tbl[15] = '{1'b0, 20'h00030, 1'b1, 1'b0, 1'b0, 16'hA5E3, 20'h00030};
        tbl[16] = '{1'b0, 20'h00030, 1'b1, 1'b0, 1'b0, 16'hA5E3, 20'h00030};
        tbl[17] = '{1'b0, 20'h00030, 1'b1, 1'b1, 1'b1, 16'hA5F3, 20'h00030};
        tbl[18] = '{1'b0, 20'h00030, 1'b1, 1'b0, 1'b1, 16'hA5F3, 20'h00030};
        tbl[19] = '{1'b0, 20'h00030, 1'b1, 1'b0, 1'b1, 16'hA5F3, 20'h00030};

        rst_n = 1'b0; rdy = 1'b1; bump = 16'h0000;
        bi0.req = 1'b0; bi0.adr = '0; bi0.inv = 1'b0;
        bi1.req = 1'b0; bi1.adr = '0; bi1.inv = 1'b0;
        repeat (3) tick();
        check("rst0 ack",  32'(bi0.ack),      32'd0);
        check("rst0 oe_n", 32'(bi0.mem_oe_n), 32'd1);
        check("rst0 dtr",  32'(bi0.dtr),      32'd0);
        check("rst0 madr", 32'(bi0.mem_adr),  32'd0);
        check("rst1 ack",  32'(bi1.ack),      32'd0);
        check("rst1 oe_n", 32'(bi1.mem_oe_n), 32'd1);
        rst_n = 1'b1;

        // Non-speculating instance: miss timing, rdy stall, req dropped mid-read.
        for (int i = 0; i < 20; i++) begin
            bi0.req = tbl[i].req;
            bi0.adr = tbl[i].adr;
            rdy     = tbl[i].rdy;
            tick();
            check($sformatf("tbl[%0d] ack", i),  32'(bi0.ack),      32'(tbl[i].ack));
            check($sformatf("tbl[%0d] oe_n", i), 32'(bi0.mem_oe_n), 32'(tbl[i].oe_n));
            check($sformatf("tbl[%0d] dtr", i),  32'(bi0.dtr),      32'(tbl[i].dtr));
            check($sformatf("tbl[%0d] madr", i), 32'(bi0.mem_adr),  32'(tbl[i].madr));
        end
        rdy = 1'b1;

        // Miss at 0x100, speculation fills 0x101, then a 1-cycle hit.
        bi1.req = 1'b1; bi1.adr = 20'h00100;
        run_to_ack(20, n);
        check("A miss edges", 32'(n), 32'd4);
        check("A miss dtr",   32'(bi1.dtr), 32'(memval(20'h00100)));
        check("A spec adr",   32'(bi1.mem_adr), 32'h00101);
        bi1.req = 1'b0;
        repeat (5) tick();
        check("A idle oe_n", 32'(bi1.mem_oe_n), 32'd1);
        bi1.req = 1'b1; bi1.adr = 20'h00101;
        tick();
        check("A hit ack",  32'(bi1.ack),      32'd1);
        check("A hit dtr",  32'(bi1.dtr),      32'(memval(20'h00101)));
        check("A hit oe_n", 32'(bi1.mem_oe_n), 32'd1);
        bi1.req = 1'b0;
        tick();
        check("A spec102 oe_n", 32'(bi1.mem_oe_n), 32'd0);
        check("A spec102 adr",  32'(bi1.mem_adr),  32'h00102);
        repeat (3) tick();
        check("A spec102 done", 32'(bi1.mem_oe_n), 32'd1);

        // Hit 0x102, then 0x103 arrives during its speculative read.
        bi1.req = 1'b1; bi1.adr = 20'h00102;
        tick();
        check("B hit ack", 32'(bi1.ack), 32'd1);
        bi1.adr = 20'h00103;
        run_to_ack(20, n);
        check("B pend edges", 32'(n), 32'd4);
        check("B pend dtr",   32'(bi1.dtr), 32'(memval(20'h00103)));
        bi1.req = 1'b0;
        tick();
        check("B single ack", 32'(bi1.ack),      32'd0);
        check("B spec104 oe", 32'(bi1.mem_oe_n), 32'd0);

        // Unrelated 0x300 during the 0x104 speculation: finish it, then demand read.
        bi1.req = 1'b1; bi1.adr = 20'h00300;
        run_to_ack(20, n);
        check("K kill edges", 32'(n), 32'd7);
        check("K kill dtr",   32'(bi1.dtr), 32'(memval(20'h00300)));
        bi1.req = 1'b0;
        tick();
        check("K single ack", 32'(bi1.ack), 32'd0);
        repeat (3) tick();
        check("K spec301 done", 32'(bi1.mem_oe_n), 32'd1);

        // Invalidate the buffered 0x301, memory changes, request must miss.
        bi1.inv = 1'b1;
        tick();
        bi1.inv = 1'b0; bump = 16'h1111;
        bi1.req = 1'b1; bi1.adr = 20'h00301;
        run_to_ack(20, n);
        check("I inv miss edges", 32'(n), 32'd4);
        check("I inv miss dtr",   32'(bi1.dtr), 32'(memval(20'h00301)));
        bi1.req = 1'b0;
        repeat (4) tick();

        // Invalidate in the same cycle as a would-be hit on 0x302.
        bi1.req = 1'b1; bi1.adr = 20'h00302; bi1.inv = 1'b1;
        tick();
        bi1.inv = 1'b0;
        check("H inv-hit ack",  32'(bi1.ack),      32'd0);
        check("H inv-hit oe_n", 32'(bi1.mem_oe_n), 32'd0);
        run_to_ack(20, n);
        check("H inv-hit edges", 32'(n), 32'd3);
        check("H inv-hit dtr",   32'(bi1.dtr), 32'(memval(20'h00302)));
        bi1.req = 1'b0;
        repeat (4) tick();

        // Reset in the middle of a demand read.
        bi1.req = 1'b1; bi1.adr = 20'h00500;
        tick();
        tick();
        check("R pre oe_n", 32'(bi1.mem_oe_n), 32'd0);
        rst_n = 1'b0; bi1.req = 1'b0;
        tick();
        check("R oe_n", 32'(bi1.mem_oe_n), 32'd1);
        check("R ack",  32'(bi1.ack),      32'd0);
        check("R dtr",  32'(bi1.dtr),      32'd0);
        check("R madr", 32'(bi1.mem_adr),  32'd0);
        rst_n = 1'b1;

        // Speculation past the top of the address space wraps to 0.
        bi1.req = 1'b1; bi1.adr = 20'hFFFFE;
        run_to_ack(20, n);
        check("W miss edges", 32'(n), 32'd4);
        check("W spec adr",   32'(bi1.mem_adr), 32'hFFFFF);
        bi1.req = 1'b0;
        repeat (4) tick();
        bi1.req = 1'b1; bi1.adr = 20'hFFFFF;
        tick();
        check("W hit ack",  32'(bi1.ack),     32'd1);
        check("W hit dtr",  32'(bi1.dtr),     32'(memval(20'hFFFFF)));
        check("W wrap adr", 32'(bi1.mem_adr), 32'h00000);
        bi1.req = 1'b0;
        tick();
        check("W wrap oe_n", 32'(bi1.mem_oe_n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
